// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array result path.
//   ACC_WIDTH_DEF : default accumulator width of the 2x2 array results
//   elem_idx_t    : element index within a 2x2 tile, {row,col}
//   tile_t        : one whole 2x2 result tile at the default width
//   drain_state_t : drain FSM state, with constants ST_IDLE / ST_STREAM
package systolic_pkg;

    localparam int unsigned ACC_WIDTH_DEF = 9;

    typedef enum logic [1:0] {
        E00 = 2'd0,
        E01 = 2'd1,
        E10 = 2'd2,
        E11 = 2'd3
    } elem_idx_t;

    typedef struct packed {
        logic [ACC_WIDTH_DEF-1:0] c00;
        logic [ACC_WIDTH_DEF-1:0] c01;
        logic [ACC_WIDTH_DEF-1:0] c10;
        logic [ACC_WIDTH_DEF-1:0] c11;
    } tile_t;

    typedef logic [0:0] drain_state_t;
    localparam drain_state_t ST_IDLE   = 1'b0;
    localparam drain_state_t ST_STREAM = 1'b1;

endpackage

// File: rtl/systolic_result_drain_if.sv
// Bundle of the tile capture side and the element stream side of the result drain.
//   master modport : the environment (array + writeback stage + control)
//   slave  modport : the drain block itself
// Signals:
//   tile_valid, c00..c11 : one-cycle tile pulse from the array with its four results
//   clr_ovf              : clear the sticky overflow flag
//   out_valid/out_ready  : element stream handshake
//   out_data/out_idx     : element value and {row,col} index
//   out_last             : last element of the tile
//   tile_count           : tiles held, including the one being streamed
//   overflow             : sticky tile-dropped flag
interface systolic_result_drain_if #(
    parameter int unsigned ACC_WIDTH  = systolic_pkg::ACC_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH  = systolic_pkg::ACC_WIDTH_DEF,
    parameter int unsigned TILE_DEPTH = 2
);
    localparam int unsigned CNT_WIDTH = $clog2(TILE_DEPTH + 1);

    logic                  tile_valid;
    logic [ACC_WIDTH-1:0]  c00;
    logic [ACC_WIDTH-1:0]  c01;
    logic [ACC_WIDTH-1:0]  c10;
    logic [ACC_WIDTH-1:0]  c11;
    logic                  clr_ovf;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [1:0]            out_idx;
    logic                  out_last;
    logic [CNT_WIDTH-1:0]  tile_count;
    logic                  overflow;

    modport master (
        output tile_valid, c00, c01, c10, c11, clr_ovf, out_ready,
        input  out_valid, out_data, out_idx, out_last, tile_count, overflow
    );

    modport slave (
        input  tile_valid, c00, c01, c10, c11, clr_ovf, out_ready,
        output out_valid, out_data, out_idx, out_last, tile_count, overflow
    );

endinterface

// File: rtl/tile_fifo.sv
// Register FIFO of whole tiles. A push is accepted when not full, or when full and the head
// is popped at the same edge. Pops of an empty FIFO are ignored.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : push request, i_data is the tile
//   i_pop      : pop request for the head entry
//   o_push_ok  : push is accepted at this edge
//   o_head     : head entry (don't-care when empty)
//   o_count    : entries held
module tile_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic                         o_push_ok,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    assign o_push_ok = i_push && (!w_full || w_pop_ok);
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (o_push_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (o_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({o_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures 2x2 result tiles from the systolic array on its valid pulse, buffers whole tiles
// and streams each tile as four elements c00,c01,c10,c11 over a valid/ready interface.
// Tiles that arrive while the buffer is full (and no head pop frees a slot) are dropped and
// flagged in a sticky overflow bit.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : systolic_result_drain_if.slave (tile input, element stream, status)
// Configuration:
//   RESULT_SAT_EN defined : out_data clamps to 2**OUT_WIDTH-1 when the result exceeds it
//   RESULT_SAT_EN absent  : out_data is the low OUT_WIDTH bits of the result
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned TILE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_result_drain_if.slave bus
);
    localparam int unsigned CNT_WIDTH = $clog2(TILE_DEPTH + 1);

    logic [3:0][ACC_WIDTH-1:0] w_wr_tile;
    logic [3:0][ACC_WIDTH-1:0] w_head;
    logic [CNT_WIDTH-1:0]      w_count;
    logic                      w_xfer;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;
    drain_state_t              r_state;
    drain_state_t              w_state_d;
    elem_idx_t                 r_idx;
    logic                      r_ovf;

    // Element k of the packed tile is the element with out_idx == k.
    assign w_wr_tile = {bus.c11, bus.c10, bus.c01, bus.c00};

    assign w_xfer = (r_state == ST_STREAM) && bus.out_ready;
    assign w_pop  = w_xfer && (r_idx == E11);
    assign w_drop = bus.tile_valid && !w_push;

    tile_fifo #(
        .WIDTH (4 * ACC_WIDTH),
        .DEPTH (TILE_DEPTH)
    ) u_tile_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (bus.tile_valid),
        .i_pop     (w_pop),
        .i_data    (w_wr_tile),
        .o_push_ok (w_push),
        .o_head    (w_head),
        .o_count   (w_count)
    );

    // STREAM is held exactly while the FIFO holds at least one tile.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_pop && !w_push && (w_count == CNT_WIDTH'(1))) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= E00;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // Wraps 3 -> 0 on the last element, which is also the pop.
            if (w_xfer) begin
                r_idx <= elem_idx_t'(r_idx + 2'd1);
            end
            // A drop at the same edge as a clear leaves the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef RESULT_SAT_EN
    localparam logic [ACC_WIDTH-1:0] MAX_OUT = ACC_WIDTH'((33'd1 << OUT_WIDTH) - 33'd1);
    assign bus.out_data = (w_head[r_idx] > MAX_OUT) ? OUT_WIDTH'(MAX_OUT)
                                                    : OUT_WIDTH'(w_head[r_idx]);
`else
    assign bus.out_data = OUT_WIDTH'(w_head[r_idx]);
`endif

    assign bus.out_valid  = (r_state == ST_STREAM);
    assign bus.out_idx    = r_idx;
    assign bus.out_last   = (r_state == ST_STREAM) && (r_idx == E11);
    assign bus.tile_count = w_count;
    assign bus.overflow   = r_ovf;

endmodule
